// File: rtl/sudoku_pkg.sv
// sudoku_pkg -- shared types and constants for the sudoku datapath blocks.
//   GRID_LEN          : row length, taken from grid_dimensions.svh
//   IDX_W             : width of a table index / shuffle counter
//   bias_state_e      : row_bias sequencing states
//   LFSR_*            : 16-bit Fibonacci LFSR parameters (taps 16,14,13,11)
`include "grid_dimensions.svh"

package sudoku_pkg;

  localparam int GRID_LEN = `GRID_LEN;
  localparam int IDX_W    = $clog2(GRID_LEN);

  localparam int                    LFSR_WIDTH        = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS         = 16'hB400;

  typedef enum logic [1:0] {
    BIAS_INIT    = 2'd0,
    BIAS_SHUFFLE = 2'd1,
    BIAS_READY   = 2'd2
  } bias_state_e;

  // One LFSR step: shift toward the MSB, XOR of the taps enters bit 0.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/row_bias_if.sv
// row_bias_if -- request/reply bundle between the tiles of a row and row_bias.
//   seed        : LFSR seed, sampled by row_bias while reset is high
//   rq_valtotry : per-tile request strobe (bit t = tile t)
//   biasidx     : per-tile 1-hot index, tile t at [t*GRID_LEN +: GRID_LEN]
//   valtotry    : registered 1-hot reply shared by the row
//   ready       : shuffle complete, requests are served
//   collide     : one-cycle pulse when several tiles requested together
// Modports: master = tile side, slave = row_bias.
interface row_bias_if;
  import sudoku_pkg::*;

  logic [LFSR_WIDTH-1:0]        seed;
  logic [GRID_LEN-1:0]          rq_valtotry;
  logic [GRID_LEN*GRID_LEN-1:0] biasidx;
  logic [GRID_LEN-1:0]          valtotry;
  logic                         ready;
  logic                         collide;

  modport master (
    output seed, rq_valtotry, biasidx,
    input  valtotry, ready, collide
  );

  modport slave (
    input  seed, rq_valtotry, biasidx,
    output valtotry, ready, collide
  );
endinterface

// File: rtl/grid_dimensions.svh
// Grid geometry shared by the sudoku datapath blocks.
// GRID_LEN: number of tiles per row (and values per tile).
`ifndef GRID_DIMENSIONS_SVH
`define GRID_DIMENSIONS_SVH
`define GRID_LEN 9
`endif

// File: rtl/row_bias_lfsr16.sv
// lfsr16 -- 16-bit Fibonacci LFSR (taps 16,14,13,11), reusable by any
// randomised block.
//   clock   : sole clock
//   reset   : synchronous active-high; loads seed (default seed if seed == 0)
//   seed    : seed value sampled while reset is high
//   advance : step the register by one on this edge
//   state   : current LFSR contents
module lfsr16
  import sudoku_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic                  advance,
  output logic [LFSR_WIDTH-1:0] state
);

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (advance) state_d = lfsr_next(state_q);
  end

  // An all-zero seed would lock the LFSR, so substitute the default.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= (seed == '0) ? LFSR_DEFAULT_SEED : seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/row_bias.sv
// row_bias -- per-row bias table: a random permutation of the GRID_LEN
// 1-hot values, built by a Fisher-Yates shuffle after reset and then used
// to translate tile index requests into 1-hot candidate values.
//   clock     : sole clock
//   reset     : synchronous active-high reset (restarts the shuffle)
//   reshuffle : (only with ROW_BIAS_RESHUFFLE_EN) start a new shuffle in READY
//   bus       : row_bias_if.slave (seed, requests, reply, ready, collide)
// Build option: define ROW_BIAS_RESHUFFLE_EN to add the reshuffle port.
//
// state        | meaning
// BIAS_INIT    | loaded by reset; identity table, k = GRID_LEN-1; the first
//              | swap is done on the release edge so the shuffle lasts
//              | exactly GRID_LEN-1 cycles
// BIAS_SHUFFLE | one swap of entries k and lfsr mod (k+1) per cycle
// BIAS_READY   | table frozen, requests served with one-cycle latency
module row_bias
  import sudoku_pkg::*;
(
  input  logic clock,
  input  logic reset,
`ifdef ROW_BIAS_RESHUFFLE_EN
  input  logic reshuffle,
`endif
  row_bias_if.slave bus
);

  bias_state_e         state_q, state_d;
  logic [IDX_W-1:0]    k_q, k_d;
  logic [GRID_LEN-1:0] bias_q [GRID_LEN];
  logic [GRID_LEN-1:0] bias_d [GRID_LEN];
  logic [GRID_LEN-1:0] valtotry_q, valtotry_d;
  logic                collide_q, collide_d;

  logic [LFSR_WIDTH-1:0] lfsr_state;
  logic [LFSR_WIDTH-1:0] j_wide;
  logic [IDX_W-1:0]      j;
  logic                  lfsr_adv;
  logic [GRID_LEN-1:0]   req_idx;
  logic [GRID_LEN-1:0]   reply;
  logic                  multi_req;

  lfsr16 u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .seed    (bus.seed),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    bias_d     = bias_q;
    valtotry_d = valtotry_q;
    collide_d  = 1'b0;
    lfsr_adv   = 1'b0;

    // j <= k always holds, so the truncation to IDX_W bits is lossless.
    j_wide = lfsr_state % (LFSR_WIDTH'(k_q) + LFSR_WIDTH'(1));
    j      = IDX_W'(j_wide);

    // Lowest-numbered requesting tile wins: scan from the top down so the
    // last hit is the lowest index.
    req_idx = '0;
    for (int t = GRID_LEN - 1; t >= 0; t--) begin
      if (bus.rq_valtotry[t]) req_idx = bus.biasidx[t*GRID_LEN +: GRID_LEN];
    end

    // OR of every addressed entry; a zero index yields zero and a
    // multi-hot index yields the union.
    reply = '0;
    for (int i = 0; i < GRID_LEN; i++) begin
      if (req_idx[i]) reply = reply | bias_q[i];
    end

    multi_req = (bus.rq_valtotry & (bus.rq_valtotry - GRID_LEN'(1))) != '0;

    case (state_q)
      BIAS_INIT, BIAS_SHUFFLE: begin
        bias_d[k_q] = bias_q[j];
        bias_d[j]   = bias_q[k_q];
        lfsr_adv    = 1'b1;
        k_d         = k_q - IDX_W'(1);
        state_d     = (k_q == IDX_W'(1)) ? BIAS_READY : BIAS_SHUFFLE;
      end
      BIAS_READY: begin
`ifdef ROW_BIAS_RESHUFFLE_EN
        // Reshuffle continues from the current table and LFSR; any
        // request in the same cycle is dropped.
        if (reshuffle) begin
          state_d    = BIAS_SHUFFLE;
          k_d        = IDX_W'(GRID_LEN - 1);
          valtotry_d = '0;
        end else if (bus.rq_valtotry != '0) begin
          valtotry_d = reply;
          collide_d  = multi_req;
        end
`else
        if (bus.rq_valtotry != '0) begin
          valtotry_d = reply;
          collide_d  = multi_req;
        end
`endif
      end
      default: state_d = BIAS_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= BIAS_INIT;
      k_q        <= IDX_W'(GRID_LEN - 1);
      valtotry_q <= '0;
      collide_q  <= 1'b0;
      for (int i = 0; i < GRID_LEN; i++) begin
        bias_q[i] <= GRID_LEN'(1) << i;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      valtotry_q <= valtotry_d;
      collide_q  <= collide_d;
      bias_q     <= bias_d;
    end
  end

  assign bus.valtotry = valtotry_q;
  assign bus.ready    = (state_q == BIAS_READY);
  assign bus.collide  = collide_q;

endmodule
